// File: rtl/spi_loopback_core.sv
// SPI master and slave joined back-to-back in one clock domain, paced by a
// free-running clock-enable divider. The master drives SCLK/SS/MOSI and the
// slave answers on MISO, so each side ends up with the other's word.
module spi_loopback_core #(
  parameter int M = 15,  // word width in bits (>= 2)
  parameter int T = 10   // GCLK cycles between ce ticks (clamped to >= 2)
) (
  input  logic         GCLK,
  input  logic         RST,
  input  logic         st,
  input  logic         LEFT,
  input  logic [M-1:0] MASTER_TX,
  input  logic [M-1:0] SLAVE_TX,
  output logic [M-1:0] MASTER_RX,
  output logic [M-1:0] SLAVE_RX,
  output logic         SCLK,
  output logic         SS,
  output logic         MOSI,
  output logic         MISO,
  output logic         busy,
  output logic         done
);

  localparam int TE = (T < 2) ? 2 : T;
  localparam int CW = $clog2(TE);
  localparam int BW = $clog2(M + 1);

  typedef enum logic [1:0] {
    M_IDLE,
    M_ARM,
    M_XFER
  } mstate_t;

  // divider
  logic [CW-1:0] div_q, div_d;
  logic          ce;

  // master
  mstate_t       state_q, state_d;
  logic          st_q, st_d;
  logic          left_q, left_d;
  logic [M-1:0]  mtx_sh_q, mtx_sh_d;
  logic [M-1:0]  mrx_sh_q, mrx_sh_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          sclk_q, sclk_d;
  logic          ss_q, ss_d;
  logic          mosi_q, mosi_d;
  logic [M-1:0]  mrx_q, mrx_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  // slave
  logic          s_sclk_q, s_sclk_d;
  logic          s_ss_q, s_ss_d;
  logic [M-1:0]  s_tx_sh_q, s_tx_sh_d;
  logic [M-1:0]  s_rx_sh_q, s_rx_sh_d;
  logic          miso_q, miso_d;
  logic [M-1:0]  srx_q, srx_d;
  logic          srx_load_q, srx_load_d;
  logic          sclk_rise, sclk_fall, ss_fall, ss_rise;

  // Divider: count 0..TE-1, ce marks the wrap; never restarted by st.
  always_comb begin
    ce    = (div_q == CW'(TE - 1));
    div_d = ce ? '0 : div_q + CW'(1);
  end

  // Master next-state: arm on st rising edge, then walk SCLK phases on ce.
  always_comb begin
    state_d   = state_q;
    st_d      = st;
    left_d    = left_q;
    mtx_sh_d  = mtx_sh_q;
    mrx_sh_d  = mrx_sh_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    ss_d      = ss_q;
    mosi_d    = mosi_q;
    mrx_d     = mrx_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    unique case (state_q)
      M_IDLE: begin
        if (st && !st_q) begin
          state_d = M_ARM;
          busy_d  = 1'b1;
        end
      end
      M_ARM: begin
        if (ce) begin
          state_d   = M_XFER;
          ss_d      = 1'b0;
          sclk_d    = 1'b0;
          left_d    = LEFT;
          mtx_sh_d  = MASTER_TX;
          mosi_d    = LEFT ? MASTER_TX[M-1] : MASTER_TX[0];
          bit_cnt_d = '0;
        end
      end
      M_XFER: begin
        if (ce) begin
          if (!sclk_q) begin
            // rising edge: capture the slave's current bit
            sclk_d    = 1'b1;
            mrx_sh_d  = left_q ? {mrx_sh_q[M-2:0], MISO} : {MISO, mrx_sh_q[M-1:1]};
            bit_cnt_d = bit_cnt_q + BW'(1);
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == BW'(M)) begin
              // last falling edge closes the frame
              ss_d    = 1'b1;
              mrx_d   = mrx_sh_q;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = M_IDLE;
            end else begin
              mtx_sh_d = left_q ? {mtx_sh_q[M-2:0], 1'b0} : {1'b0, mtx_sh_q[M-1:1]};
              mosi_d   = left_q ? mtx_sh_q[M-2] : mtx_sh_q[1];
            end
          end
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  // Slave edge detection against one registered copy of SCLK and SS.
  always_comb begin
    sclk_rise = sclk_q & ~s_sclk_q;
    sclk_fall = ~sclk_q & s_sclk_q;
    ss_fall   = ~ss_q & s_ss_q;
    ss_rise   = ss_q & ~s_ss_q;
  end

  // Slave next-state: load on SS fall, sample/shift on SCLK edges, publish on SS rise.
  always_comb begin
    s_sclk_d   = sclk_q;
    s_ss_d     = ss_q;
    s_tx_sh_d  = s_tx_sh_q;
    s_rx_sh_d  = s_rx_sh_q;
    miso_d     = miso_q;
    srx_d      = srx_q;
    srx_load_d = ss_rise;
    if (srx_load_q) begin
      srx_d = s_rx_sh_q;
    end
    if (ss_rise) begin
      miso_d = 1'b0;
    end else if (ss_fall) begin
      s_tx_sh_d = SLAVE_TX;
      miso_d    = left_q ? SLAVE_TX[M-1] : SLAVE_TX[0];
    end else if (!s_ss_q) begin
      if (sclk_rise) begin
        s_rx_sh_d = left_q ? {s_rx_sh_q[M-2:0], mosi_q} : {mosi_q, s_rx_sh_q[M-1:1]};
      end else if (sclk_fall) begin
        s_tx_sh_d = left_q ? {s_tx_sh_q[M-2:0], 1'b0} : {1'b0, s_tx_sh_q[M-1:1]};
        miso_d    = left_q ? s_tx_sh_q[M-2] : s_tx_sh_q[1];
      end
    end
  end

  // State registers for divider, master and slave; reset aborts everything.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      div_q      <= '0;
      state_q    <= M_IDLE;
      st_q       <= 1'b0;
      left_q     <= 1'b0;
      mtx_sh_q   <= '0;
      mrx_sh_q   <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      mrx_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      s_sclk_q   <= 1'b0;
      s_ss_q     <= 1'b1;
      s_tx_sh_q  <= '0;
      s_rx_sh_q  <= '0;
      miso_q     <= 1'b0;
      srx_q      <= '0;
      srx_load_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      state_q    <= state_d;
      st_q       <= st_d;
      left_q     <= left_d;
      mtx_sh_q   <= mtx_sh_d;
      mrx_sh_q   <= mrx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      mrx_q      <= mrx_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      s_sclk_q   <= s_sclk_d;
      s_ss_q     <= s_ss_d;
      s_tx_sh_q  <= s_tx_sh_d;
      s_rx_sh_q  <= s_rx_sh_d;
      miso_q     <= miso_d;
      srx_q      <= srx_d;
      srx_load_q <= srx_load_d;
    end
  end

  assign MASTER_RX = mrx_q;
  assign SLAVE_RX  = srx_q;
  assign SCLK      = sclk_q;
  assign SS        = ss_q;
  assign MOSI      = mosi_q;
  // MISO is forced low whenever the slave is deselected.
  assign MISO      = miso_q & ~ss_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_spi_loopback_core.sv
// Bench for spi_loopback_core: two instances (T=10 and T=2) share stimulus;
// expected transfers are queued at start and a negedge monitor checks them.
module tb_spi_loopback_core;

  localparam int M  = 15;
  localparam int TA = 10;
  localparam int TB = 2;

  logic clk = 1'b0;
  logic rst, st, left;
  logic [M-1:0] mtx, stx;
  logic [1:0][M-1:0] mrx, srx;
  logic [1:0] sclk, ss, mosi, miso, busy, done;

  always #5 clk = ~clk;

  spi_loopback_core #(.M(M), .T(TA)) dut_a (
    .GCLK(clk), .RST(rst), .st(st), .LEFT(left),
    .MASTER_TX(mtx), .SLAVE_TX(stx),
    .MASTER_RX(mrx[0]), .SLAVE_RX(srx[0]),
    .SCLK(sclk[0]), .SS(ss[0]), .MOSI(mosi[0]), .MISO(miso[0]),
    .busy(busy[0]), .done(done[0])
  );

  spi_loopback_core #(.M(M), .T(TB)) dut_b (
    .GCLK(clk), .RST(rst), .st(st), .LEFT(left),
    .MASTER_TX(mtx), .SLAVE_TX(stx),
    .MASTER_RX(mrx[1]), .SLAVE_RX(srx[1]),
    .SCLK(sclk[1]), .SS(ss[1]), .MOSI(mosi[1]), .MISO(miso[1]),
    .busy(busy[1]), .done(done[1])
  );

  typedef struct packed {
    logic [M-1:0] mtx;
    logic [M-1:0] stx;
    logic         left;
  } xfer_t;

  xfer_t q_a[$];
  xfer_t q_b[$];

  int checks = 0;
  int errors = 0;

  // Reference: bit k on the wire for word w under order l.
  function automatic logic [M-1:0] wire_order(input logic [M-1:0] w, input logic l);
    logic [M-1:0] r;
    for (int k = 0; k < M; k++) r[k] = l ? w[M-1-k] : w[k];
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int rises [2] = '{0, 0};
  int low_cnt [2] = '{0, 0};
  int last_rise [2] = '{0, 0};
  int age [2] = '{0, 0};
  int srx_pend [2] = '{0, 0};
  logic [M-1:0] exp_srx [2];
  logic [M-1:0] mosi_w [2];
  logic [M-1:0] miso_w [2];
  logic sclk_prev [2] = '{1'b0, 1'b0};
  logic rst_prev = 1'b0;
  int cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int tp;
      int sz;
      xfer_t e;
      tp = (i == 0) ? TA : TB;
      if (rst) begin
        if (rst_prev) begin
          checks++;
          if (sclk[i] !== 1'b0 || ss[i] !== 1'b1 || mosi[i] !== 1'b0 || miso[i] !== 1'b0 ||
              mrx[i] !== '0 || srx[i] !== '0 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state[%0d]: got sclk=%b ss=%b mosi=%b miso=%b mrx=%h srx=%h busy=%b done=%b, want 0 1 0 0 0 0 0 0",
                     i, sclk[i], ss[i], mosi[i], miso[i], mrx[i], srx[i], busy[i], done[i]);
          end
        end
        rises[i] = 0; low_cnt[i] = 0; age[i] = 0; srx_pend[i] = 0;
        if (i == 0) q_a.delete(); else q_b.delete();
      end else begin
        if (!ss[i]) low_cnt[i]++;
        if (ss[i]) begin
          checks++;
          if (miso[i] !== 1'b0) begin
            errors++;
            $display("FAIL miso_idle[%0d]: got %b want 0 while SS high", i, miso[i]);
          end
        end
        if (sclk[i] && !sclk_prev[i]) begin
          if (rises[i] > 0) begin
            checks++;
            if (cyc - last_rise[i] != 2 * tp) begin
              errors++;
              $display("FAIL sclk_period[%0d]: got %0d want %0d", i, cyc - last_rise[i], 2 * tp);
            end
          end
          last_rise[i] = cyc;
          if (rises[i] < M) begin
            mosi_w[i][rises[i]] = mosi[i];
            miso_w[i][rises[i]] = miso[i];
          end
          rises[i]++;
        end
        sz = (i == 0) ? q_a.size() : q_b.size();
        if (sz > 0) age[i]++;
        if (done[i]) begin
          checks++;
          if (sz == 0) begin
            errors++;
            $display("FAIL unexpected_done[%0d]: got done=1 want no transfer pending", i);
          end else begin
            e = (i == 0) ? q_a.pop_front() : q_b.pop_front();
            checks += 4;
            if (mrx[i] !== e.stx) begin
              errors++;
              $display("FAIL master_rx[%0d]: got %h want %h", i, mrx[i], e.stx);
            end
            if (rises[i] != M) begin
              errors++;
              $display("FAIL sclk_rises[%0d]: got %0d want %0d", i, rises[i], M);
            end
            if (low_cnt[i] != 2 * M * tp) begin
              errors++;
              $display("FAIL ss_low_cycles[%0d]: got %0d want %0d", i, low_cnt[i], 2 * M * tp);
            end
            if (mosi_w[i] !== wire_order(e.mtx, e.left) || miso_w[i] !== wire_order(e.stx, e.left)) begin
              errors++;
              $display("FAIL wire_bits[%0d]: got mosi=%h miso=%h want %h %h", i,
                       mosi_w[i], miso_w[i], wire_order(e.mtx, e.left), wire_order(e.stx, e.left));
            end
            $display("xfer[%0d] t=%0d left=%b mtx=%h stx=%h -> mrx=%h", i, cyc, e.left, e.mtx, e.stx, mrx[i]);
            exp_srx[i] = e.mtx;
            srx_pend[i] = 2;
          end
          rises[i] = 0; low_cnt[i] = 0; age[i] = 0;
        end else if (srx_pend[i] > 0) begin
          srx_pend[i]--;
          if (srx_pend[i] == 0) begin
            checks++;
            if (srx[i] !== exp_srx[i]) begin
              errors++;
              $display("FAIL slave_rx[%0d]: got %h want %h", i, srx[i], exp_srx[i]);
            end
          end
        end
        if (age[i] > 2 * M * tp + 8 * tp + 20) begin
          checks++;
          errors++;
          $display("FAIL timeout[%0d]: no done within %0d cycles", i, age[i]);
          if (i == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
          age[i] = 0;
        end
      end
      sclk_prev[i] = sclk[i];
    end
    rst_prev = rst;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_xfer();
    xfer_t e;
    e.mtx = mtx; e.stx = stx; e.left = left;
    q_a.push_back(e);
    q_b.push_back(e);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && (q_a.size() != 0 || q_b.size() != 0); k++) tick(1);
    tick(6);
  endtask

  task automatic run_pulse(input logic [M-1:0] m, input logic [M-1:0] s, input logic l, input int w);
    mtx = m; stx = s; left = l;
    expect_xfer();
    st = 1'b1;
    tick(w);
    st = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; st = 1'b0; left = 1'b1; mtx = '0; stx = '0;
    tick(3);
    rst = 1'b0;
    tick(3);

    // directed words, both bit orders
    run_pulse(15'h2C36, 15'h6B36, 1'b1, 10);
    run_pulse(15'h2C36, 15'h6B36, 1'b0, 10);
    run_pulse(15'h7FFF, 15'h0001, 1'b1, 2);
    run_pulse(15'h7FFF, 15'h0001, 1'b0, 2);

    // st held high: one transfer only; then a fresh edge runs another
    mtx = 15'h2C36; stx = 15'h6B36; left = 1'b1;
    expect_xfer();
    st = 1'b1;
    tick(1000);
    st = 1'b0;
    tick(4);
    run_pulse(15'h2C36, 15'h6B36, 1'b1, 3);

    // extra st pulses while busy are ignored
    mtx = 15'h1234; stx = 15'h4321; left = 1'b0;
    expect_xfer();
    st = 1'b1; tick(2); st = 1'b0; tick(18);
    st = 1'b1; tick(2); st = 1'b0; tick(18);
    st = 1'b1; tick(2); st = 1'b0;
    wait_idle();

    // reset at the 7th SCLK rise of the slow instance
    mtx = 15'h5A5A; stx = 15'h2DD2; left = 1'b1;
    expect_xfer();
    st = 1'b1; tick(2); st = 1'b0;
    begin
      int r;
      logic p;
      r = 0; p = sclk[0];
      for (int k = 0; k < 3000 && r < 7; k++) begin
        @(negedge clk);
        if (sclk[0] && !p) r++;
        p = sclk[0];
      end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    run_pulse(15'h0F0F, 15'h70F0, 1'b1, 2);

    // randomized transfers; inputs scrambled once both slaves have latched
    for (int n = 0; n < 8; n++) begin
      mtx = M'($urandom); stx = M'($urandom); left = 1'($urandom);
      expect_xfer();
      st = 1'b1; tick(2); st = 1'b0;
      for (int k = 0; k < 200 && (ss[0] || ss[1]); k++) tick(1);
      tick(2);
      mtx = M'($urandom); stx = M'($urandom); left = 1'($urandom);
      wait_idle();
    end

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
